stack_arbiter: RTL and testbench

- Two-client controller that shares one `stack` instance (push/pop/init, WIDTH-bit data) between requesters.
- Arbitrates requests round-robin and sequences exactly one stack operation per grant.
- Tracks occupancy so the stack never overflows or underflows.
- Returns pop data through a request/acknowledge handshake. Sits between the maze-solver datapath clients and the stack.

---
 rtl/stack_arbiter_if.sv | 41 ++++
 rtl/stack_arbiter.sv | 112 +++++++++++
 tb/tb_stack_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// rtl/stack_arbiter_if.sv - client, status and stack-side signals of stack_arbiter
// slave is the arbiter's view; master is the clients/stack environment view.
interface stack_arbiter_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH);

  logic             clr;
  logic             c0_req;
  logic             c0_op;
  logic [WIDTH-1:0] c0_din;
  logic             c0_ack;
  logic             c0_err;
  logic             c1_req;
  logic             c1_op;
  logic [WIDTH-1:0] c1_din;
  logic             c1_ack;
  logic             c1_err;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             stk_init;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;

  modport slave (
    input  clr, c0_req, c0_op, c0_din, c1_req, c1_op, c1_din, stk_dout,
    output c0_ack, c0_err, c1_ack, c1_err, rd_data, count, full, empty,
           stk_init, stk_push, stk_pop, stk_din
  );

  modport master (
    output clr, c0_req, c0_op, c0_din, c1_req, c1_op, c1_din, stk_dout,
    input  c0_ack, c0_err, c1_ack, c1_err, rd_data, count, full, empty,
           stk_init, stk_push, stk_pop, stk_din
  );
endinterface

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-client round-robin arbiter sequencing one stack op per grant
// Define STACK_ARB_FIXED_PRIO_EN to make client 0 always win simultaneous requests.
module stack_arbiter #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
) (
  input  logic           CLK,
  input  logic           RST,
  stack_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             err_q, err_d;
  logic             rr_q, rr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty;
  logic sel, reject;

  assign full  = (count_q == CW'(DEPTH - 1));
  assign empty = (count_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      din_q   <= '0;
      err_q   <= 1'b0;
      rr_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      din_q   <= din_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    din_d   = din_q;
    err_d   = err_q;
    rr_d    = rr_q;
    count_d = count_q;
    sel     = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
        end else if (bus.c0_req || bus.c1_req) begin
          if (bus.c0_req && bus.c1_req) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel  = rr_q;
            rr_d = ~rr_q;
`endif
          end else begin
            sel = bus.c1_req;
          end
          gnt_d = sel;
          op_d  = sel ? bus.c1_op  : bus.c0_op;
          din_d = sel ? bus.c1_din : bus.c0_din;
          // Overflow/underflow is refused here so the stack is never touched.
          reject  = op_d ? full : empty;
          err_d   = reject;
          state_d = reject ? RESP : ISSUE;
        end
      end
      CLEAR: begin
        count_d = '0;
        state_d = IDLE;
      end
      ISSUE: begin
        count_d = op_q ? count_q + 1'b1 : count_q - 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stk_init = (state_q == CLEAR);
  assign bus.stk_push = (state_q == ISSUE) && op_q;
  assign bus.stk_pop  = (state_q == ISSUE) && !op_q;
  assign bus.stk_din  = bus.stk_push ? din_q : '0;

  assign bus.c0_ack  = (state_q == RESP) && !gnt_q;
  assign bus.c1_ack  = (state_q == RESP) && gnt_q;
  assign bus.c0_err  = bus.c0_ack && err_q;
  assign bus.c1_err  = bus.c1_ack && err_q;
  assign bus.rd_data = bus.stk_dout;

  assign bus.count = count_q;
  assign bus.full  = full;
  assign bus.empty = empty;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - scoreboard bench for stack_arbiter with a behavioural stack
module tb_stack_arbiter;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  stack_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  // Behavioural stack sharing the arbiter reset.
  logic [WIDTH-1:0] mem [DEPTH];
  int               sp;
  logic [WIDTH-1:0] dout_q;
  assign bus.stk_dout = dout_q;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp     <= 0;
      dout_q <= '0;
    end else if (bus.stk_init) begin
      sp <= 0;
    end else if (bus.stk_push && sp < DEPTH) begin
      mem[sp] <= bus.stk_din;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      dout_q <= mem[sp-1];
      sp     <= sp - 1;
    end
  end

  typedef struct {
    bit         gnt;
    bit         err;
    bit         is_pop;
    logic [1:0] rd;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] model[$];
  int         checks = 0;
  int         errors = 0;

  function automatic exp_t predict(bit c, bit op, logic [1:0] din);
    exp_t e;
    e.gnt = c; e.is_pop = !op; e.err = 1'b0; e.rd = '0;
    if (op) begin
      if (model.size() == DEPTH - 1) e.err = 1'b1;
      else model.push_back(din);
    end else begin
      if (model.size() == 0) e.err = 1'b1;
      else e.rd = model.pop_back();
    end
    return e;
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    bus.clr = 0; bus.c0_req = 0; bus.c0_op = 0; bus.c0_din = '0;
    bus.c1_req = 0; bus.c1_op = 0; bus.c1_din = '0;
    model.delete(); sb.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Single-client transaction; lat counts clock edges from the sampling edge to the ack.
  task automatic run_single(input bit c, input bit op, input logic [1:0] din,
                            output bit got, output int lat, output logic err,
                            output logic [1:0] rd, output int npush, output int npop);
    sb.push_back(predict(c, op, din));
    @(posedge CLK); #1;
    if (c) begin bus.c1_req = 1; bus.c1_op = op; bus.c1_din = din; end
    else   begin bus.c0_req = 1; bus.c0_op = op; bus.c0_din = din; end
    got = 0; lat = 0; npush = 0; npop = 0; err = 1'bx; rd = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge CLK); #1;
      lat++;
      npush += int'(bus.stk_push);
      npop  += int'(bus.stk_pop);
      if (c ? bus.c1_ack : bus.c0_ack) begin
        got = 1;
        err = c ? bus.c1_err : bus.c0_err;
        rd  = bus.rd_data;
      end
    end
    bus.c0_req = 0; bus.c1_req = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.clr = 0; bus.c0_req = 0; bus.c1_req = 0;
    @(posedge CLK); #1;
    checks++;
    if (bus.count !== 0 || bus.empty !== 1 || bus.full !== 0) begin
      errors++;
      $display("FAIL reset_status count %0d empty %0b full %0b exp 0/1/0", bus.count, bus.empty, bus.full);
    end
    checks++;
    if ({bus.c0_ack, bus.c0_err, bus.c1_ack, bus.c1_err, bus.stk_init, bus.stk_push, bus.stk_pop} !== 7'b0 || bus.stk_din !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs acks/errs/stk %b stk_din %b exp all 0", {bus.c0_ack, bus.c0_err, bus.c1_ack, bus.c1_err, bus.stk_init, bus.stk_push, bus.stk_pop}, bus.stk_din);
    end
    do_reset();
  endtask

  task automatic test_push_pop();
    exp_t e; bit got; int lat, np, nq; logic err; logic [1:0] rd;
    run_single(0, 1, 2'b10, got, lat, err, rd, np, nq);
    e = sb.pop_front();
    checks++;
    if (!got || lat !== 2) begin errors++; $display("FAIL push0_latency ack %0b cycles %0d exp 2", got, lat); end
    checks++;
    if (err !== e.err || np !== 1) begin errors++; $display("FAIL push0_op err %b pulses %0d exp %b/1", err, np, e.err); end
    checks++;
    if (bus.count !== model.size() || bus.empty !== 0) begin errors++; $display("FAIL push0_count count %0d empty %0b exp %0d/0", bus.count, bus.empty, model.size()); end

    run_single(1, 0, 2'b00, got, lat, err, rd, np, nq);
    e = sb.pop_front();
    checks++;
    if (!got || lat !== 2 || nq !== 1) begin errors++; $display("FAIL pop1_latency ack %0b cycles %0d pops %0d exp 2/1", got, lat, nq); end
    checks++;
    if (err !== e.err || rd !== e.rd) begin errors++; $display("FAIL pop1_data err %b rd %b exp %b/%b", err, rd, e.err, e.rd); end
    checks++;
    if (bus.count !== 0 || bus.empty !== 1) begin errors++; $display("FAIL pop1_count count %0d empty %0b exp 0/1", bus.count, bus.empty); end
  endtask

  task automatic test_full();
    exp_t e; bit got; int lat, np, nq; logic err; logic [1:0] rd;
    logic [1:0] vals [3];
    vals[0] = 2'b01; vals[1] = 2'b10; vals[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      run_single(0, 1, vals[k], got, lat, err, rd, np, nq);
      e = sb.pop_front();
      checks++;
      if (!got || err !== e.err || np !== 1) begin errors++; $display("FAIL fill_%0d ack %0b err %b pulses %0d exp 1/%b/1", k, got, err, np, e.err); end
    end
    checks++;
    if (bus.full !== 1 || bus.count !== 3) begin errors++; $display("FAIL full_flag full %0b count %0d exp 1/3", bus.full, bus.count); end

    run_single(0, 1, 2'b00, got, lat, err, rd, np, nq);
    e = sb.pop_front();
    checks++;
    if (!got || lat !== 1 || err !== e.err || e.err !== 1) begin errors++; $display("FAIL overflow_reject ack %0b cycles %0d err %b exp 1/1/1", got, lat, err); end
    checks++;
    if (np !== 0 || bus.count !== 3) begin errors++; $display("FAIL overflow_noop pulses %0d count %0d exp 0/3", np, bus.count); end

    run_single(1, 0, 2'b00, got, lat, err, rd, np, nq);
    e = sb.pop_front();
    checks++;
    if (!got || err !== e.err || rd !== e.rd || bus.count !== model.size()) begin
      errors++; $display("FAIL lifo_pop err %b rd %b count %0d exp %b/%b/%0d", err, rd, bus.count, e.err, e.rd, model.size());
    end
  endtask

  task automatic test_clear();
    @(posedge CLK); #1;
    bus.clr = 1;
    @(posedge CLK); #1;
    bus.clr = 0;
    checks++;
    if (bus.stk_init !== 1 || bus.c0_ack !== 0 || bus.c1_ack !== 0) begin errors++; $display("FAIL clear_init stk_init %0b exp 1", bus.stk_init); end
    @(posedge CLK); #1;
    model.delete();
    checks++;
    if (bus.stk_init !== 0 || bus.count !== 0 || bus.empty !== 1) begin
      errors++; $display("FAIL clear_done stk_init %0b count %0d empty %0b exp 0/0/1", bus.stk_init, bus.count, bus.empty);
    end
  endtask

  task automatic test_empty_pop();
    exp_t e; bit got; int lat, np, nq; logic err; logic [1:0] rd;
    run_single(0, 0, 2'b00, got, lat, err, rd, np, nq);
    e = sb.pop_front();
    checks++;
    if (!got || lat !== 1 || err !== e.err || e.err !== 1) begin errors++; $display("FAIL underflow_reject ack %0b cycles %0d err %b exp 1/1/1", got, lat, err); end
    checks++;
    if (nq !== 0 || bus.count !== 0) begin errors++; $display("FAIL underflow_noop pops %0d count %0d exp 0/0", nq, bus.count); end
  endtask

  task automatic test_back_to_back();
    int acks = 0; bit g, eg; exp_t e;
    do_reset();
    @(posedge CLK); #1;
    bus.c0_req = 1; bus.c0_op = 1; bus.c0_din = 2'b01;
    bus.c1_req = 1; bus.c1_op = 0; bus.c1_din = 2'b00;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(posedge CLK); #1;
      if (bus.c0_ack || bus.c1_ack) begin
        g = bus.c1_ack;
`ifdef STACK_ARB_FIXED_PRIO_EN
        eg = 1'b0;
`else
        eg = acks[0];
`endif
        e = predict(eg, !eg, 2'b01);
        checks++;
        if ((bus.c0_ack && bus.c1_ack) || g !== eg) begin errors++; $display("FAIL grant_%0d got client %0b exp %0b", acks, g, eg); end
        checks++;
        if ((g ? bus.c1_err : bus.c0_err) !== e.err) begin errors++; $display("FAIL grant_err_%0d err %b exp %b", acks, g ? bus.c1_err : bus.c0_err, e.err); end
        if (!e.err && e.is_pop) begin
          checks++;
          if (bus.rd_data !== e.rd) begin errors++; $display("FAIL grant_rd_%0d rd %b exp %b", acks, bus.rd_data, e.rd); end
        end
        acks++;
      end
    end
    bus.c0_req = 0; bus.c1_req = 0;
    checks++;
    if (acks !== 4) begin errors++; $display("FAIL grant_timeout acks %0d exp 4", acks); end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit got; int lat, np, nq; logic err; logic [1:0] rd; int stray = 0;
    @(posedge CLK); #1;
    bus.c0_req = 1; bus.c0_op = 1; bus.c0_din = 2'b11;
    @(posedge CLK); #1;
    checks++;
    if (bus.stk_push !== 1) begin errors++; $display("FAIL midrst_issue stk_push %0b exp 1", bus.stk_push); end
    RST = 1'b1;
    bus.c0_req = 0;
    model.delete(); sb.delete();
    #1;
    checks++;
    if (bus.count !== 0 || bus.stk_push !== 0 || bus.c0_ack !== 0) begin
      errors++; $display("FAIL midrst_abort count %0d stk_push %0b ack %0b exp 0/0/0", bus.count, bus.stk_push, bus.c0_ack);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (bus.c0_ack || bus.c1_ack) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL midrst_noack stray acks %0d exp 0", stray); end
    run_single(0, 1, 2'b10, got, lat, err, rd, np, nq);
    e = sb.pop_front();
    checks++;
    if (!got || lat !== 2 || err !== e.err || bus.count !== 1) begin
      errors++; $display("FAIL midrst_idle ack %0b cycles %0d err %b count %0d exp 1/2/%b/1", got, lat, err, bus.count, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_clear();
    test_empty_pop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
